fetch_pc_unit: RTL
==================

# fetch_pc_unit

Parametrised fetch-stage program-counter unit that supersedes the plain PC register. It generates the fetch address and drives a valid/ready request to instruction memory. It arbitrates trap, redirect, stall and sequential advance, and buffers a redirect that arrives while a request is still unaccepted. It sits at the head of IF, feeding PCF and PCPlusF to the IF/ID register.

## Interface
Parameters:
- XLEN, 64, address width
- RESET_VEC, 0, PC value after reset (XLEN bits)
- INSTR_BYTES, 4, sequential increment; power of two, 2 or 4
- BOOT_DELAY, 4, cycles after reset release before the first request; 0–15

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- StallF  in  1  hold PC; blocks advance, does not block redirect
- trap_valid  in  1  trap request, highest priority
- trap_vec  in  XLEN  trap target
- redirect_valid  in  1  branch/jump redirect from EX
- redirect_pc  in  XLEN  redirect target
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_kill  out  1  one-cycle pulse: the instruction just accepted is wrong-path and must be dropped
- PCF  out  XLEN  current fetch address, also the request address
- PCPlusF  out  XLEN  PCF + INSTR_BYTES
- misalign_err  out  1  misaligned-target pulse; tied 0 when the check is compiled out

## Operation
- States: BOOT, RUN, PEND.
- BOOT: a 4-bit counter counts BOOT_DELAY cycles, then the unit moves to RUN. imem_req_valid=0 in BOOT.
- RUN: imem_req_valid=1.
- Accept is defined as imem_req_valid && imem_req_ready.
- Next-PC priority in RUN, evaluated each cycle:
  - trap_valid: trap_vec
  - else redirect_valid: redirect_pc
  - else accept && !StallF: PCF+INSTR_BYTES
  - else hold
- Handshake stability: while imem_req_valid && !imem_req_ready, PCF must not change.
  - A trap or redirect in that cycle is captured into pend_pc. A trap overwrites a redirect captured in the same or an earlier cycle.
  - State goes to PEND.
- PEND: imem_req_valid stays 1 with the old PCF.
  - On accept, PCF<=pend_pc, imem_kill=1 for that cycle, state returns to RUN.
  - A new trap or redirect arriving in PEND replaces pend_pc.
- Trap or redirect in a cycle that accepts, or while valid=0: load directly, no kill.
- A trap or redirect during BOOT loads PCF. BOOT continues.
- Arithmetic is modulo 2^XLEN; 0xFFFF_FFFF_FFFF_FFFC+4 wraps to 0.
- PCPlusF is combinational from PCF.

## Timing
- Reset (asynchronous assert): PCF=RESET_VEC, state=BOOT, counter=0, imem_req_valid=0, imem_kill=0, misalign_err=0, pend_pc=0.
- Reset mid-PEND discards pend_pc.
- Latency:
  - BOOT_DELAY=N gives the first imem_req_valid in cycle N+1 after the first clk edge with rst_n high.
  - BOOT_DELAY=0 asserts valid after the first edge.
- Redirect/trap with the unit not blocked: PCF updates on the next edge (1-cycle latency).
- Redirect/trap while blocked: applied on the edge of the accepting cycle. imem_kill is high in that same cycle.
- StallF without accept holds PCF indefinitely. Sequential advance happens only on an edge with accept && !StallF.
- Simultaneous trap and redirect: trap wins; the redirect is lost.

## Configuration
- PC_MISALIGN_CHK_EN defined: a trap or redirect target with nonzero bits [log2(INSTR_BYTES)-1:0] is rejected.
  - misalign_err pulses for 1 cycle and PCF is unaffected.
  - An aligned trap still takes priority if both are present.
- PC_MISALIGN_CHK_EN undefined: the low bits of every target are cleared before load, and misalign_err is tied 0.

## Structure
- Shared package fetch_pkg holds:
  - the state enum pc_state_e {BOOT, RUN, PEND}
  - the localparam for the increment log2
  - the default RESET_VEC
- One natural sub-module: pc_target_sel, the combinational priority/alignment mux producing the target, a target-valid flag and misalign_err.
- The FSM and registers stay in the top.

## Test plan
- Reset release, BOOT_DELAY=4, ready=1 -> valid rises 5th cycle; PCF sequence 0,4,8,0xC.
- ready=0 for 3 cycles, redirect_pc=0x1000 in 1st -> PCF held at 0x8, kill=1 on the accept edge, next PCF=0x1000.
- StallF=1 and redirect_valid=1 with ready=1 -> PCF=redirect_pc next cycle, no kill.
- Same-cycle trap_vec=0x200 and redirect_pc=0x300 -> PCF=0x200.
- PCF=0xFFFF_FFFF_FFFF_FFFC, accept -> PCF=0, PCPlusF=4.
- With PC_MISALIGN_CHK_EN, redirect_pc=0x1002 -> misalign_err pulse, PCF advances sequentially. Without it, PCF=0x1000.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the fetch-stage PC unit.
package fetch_pkg;

    typedef enum logic [1:0] {BOOT, RUN, PEND} pc_state_e;

    localparam int unsigned DEF_INSTR_BYTES = 4;
    localparam int unsigned DEF_INC_LOG2    = 2;
    localparam logic [63:0] DEF_RESET_VEC   = 64'h0;

    // Only 2- and 4-byte instruction granules are supported.
    function automatic int unsigned inc_log2(input int unsigned bytes);
        return (bytes == 2) ? 1 : DEF_INC_LOG2;
    endfunction

endpackage

// File: rtl/pc_target_sel.sv
// Trap/redirect priority mux with target alignment handling.
// PC_MISALIGN_CHK_EN selects rejection of misaligned targets instead of silent masking.
module pc_target_sel #(
    parameter int unsigned XLEN     = 64,
    parameter int unsigned INC_LOG2 = 2
) (
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_vec,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            tgt_valid,
    output logic [XLEN-1:0] tgt_pc,
    output logic            misalign_err
);

    localparam logic [XLEN-1:0] LOW_MASK = XLEN'((1 << INC_LOG2) - 1);

    logic            req;
    logic [XLEN-1:0] raw;

    // Trap always wins; a simultaneous redirect is dropped.
    always_comb begin
        req = trap_valid | redirect_valid;
        raw = trap_valid ? trap_vec : redirect_pc;
    end

`ifdef PC_MISALIGN_CHK_EN
    always_comb begin
        misalign_err = req && (|(raw & LOW_MASK));
        tgt_valid    = req && !misalign_err;
        tgt_pc       = raw;
    end
`else
    always_comb begin
        misalign_err = 1'b0;
        tgt_valid    = req;
        tgt_pc       = raw & ~LOW_MASK;
    end
`endif

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch-stage PC generator with boot delay, valid/ready imem request and buffered redirects.
// Misaligned-target rejection is enabled by defining PC_MISALIGN_CHK_EN.
module fetch_pc_unit
    import fetch_pkg::*;
#(
    parameter int unsigned      XLEN        = 64,
    parameter logic [XLEN-1:0]  RESET_VEC   = XLEN'(DEF_RESET_VEC),
    parameter int unsigned      INSTR_BYTES = DEF_INSTR_BYTES,
    parameter int unsigned      BOOT_DELAY  = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            StallF,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_vec,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic            imem_kill,
    output logic [XLEN-1:0] PCF,
    output logic [XLEN-1:0] PCPlusF,
    output logic            misalign_err
);

    localparam int unsigned INC_LOG2 = inc_log2(INSTR_BYTES);
    localparam logic [3:0]  BOOT_CNT = 4'(BOOT_DELAY);

    pc_state_e       state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pend_q, pend_d;
    logic            mis_q;

    logic            tgt_valid;
    logic [XLEN-1:0] tgt_pc;
    logic            sel_misalign;

    pc_target_sel #(
        .XLEN     (XLEN),
        .INC_LOG2 (INC_LOG2)
    ) u_target_sel (
        .trap_valid     (trap_valid),
        .trap_vec       (trap_vec),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .tgt_valid      (tgt_valid),
        .tgt_pc         (tgt_pc),
        .misalign_err   (sel_misalign)
    );

    assign PCF          = pc_q;
    assign PCPlusF      = pc_q + XLEN'(INSTR_BYTES);
    assign misalign_err = mis_q;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        pc_d           = pc_q;
        pend_d         = pend_q;
        imem_req_valid = 1'b0;
        imem_kill      = 1'b0;
        unique case (state_q)
            BOOT: begin
                if (tgt_valid) pc_d = tgt_pc;
                if (cnt_q == BOOT_CNT) state_d = RUN;
                else                   cnt_d = cnt_q + 4'd1;
            end
            RUN: begin
                imem_req_valid = 1'b1;
                // An unaccepted request must keep its address, so targets are parked.
                if (!imem_req_ready) begin
                    if (tgt_valid) begin
                        pend_d  = tgt_pc;
                        state_d = PEND;
                    end
                end else if (tgt_valid) begin
                    pc_d = tgt_pc;
                end else if (!StallF) begin
                    pc_d = PCPlusF;
                end
            end
            PEND: begin
                imem_req_valid = 1'b1;
                if (imem_req_ready) begin
                    imem_kill = 1'b1;
                    pc_d      = tgt_valid ? tgt_pc : pend_q;
                    state_d   = RUN;
                end else if (tgt_valid) begin
                    pend_d = tgt_pc;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BOOT;
            cnt_q   <= 4'd0;
            pc_q    <= RESET_VEC;
            pend_q  <= '0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pc_q    <= pc_d;
            pend_q  <= pend_d;
            mis_q   <= sel_misalign;
        end
    end

endmodule
